// File: rtl/ysyx_25020037_ifu_pkg.sv
// Shared IFU configuration: bus width, reset PC, AXI response codes and FSM states.
package ysyx_25020037_ifu_pkg;

    localparam int unsigned FU_TO_DU_BUS_WD  = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;

    typedef enum logic [1:0] {
        IFU_ISSUE  = 2'd0,
        IFU_WAIT_R = 2'd1,
        IFU_HOLD   = 2'd2
    } ifu_state_e;

    // Sequential fetch step; wraps modulo 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: one outstanding AXI4-Lite read, {pc, inst} handed to
// decode over valid/ready, redirectable from execute.
// Optional performance counters are built when YSYX_25020037_IFU_PERF_EN is defined.
module ysyx_25020037_ifu
    import ysyx_25020037_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       idu_ready,
    output logic                       ifu_valid,
    output logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus,
    input  logic                       exu_dnpc_valid,
    input  logic [31:0]                exu_dnpc,
    output logic [31:0]                araddr,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rvalid,
    output logic                       rready,
    output logic                       ifu_access_fault,
    output logic [31:0]                perf_fetch_cnt,
    output logic [31:0]                perf_stall_cnt
);

    ifu_state_e  state;
    logic [31:0] pc;
    // Address presented on AR; kept separate from pc so a redirect cannot
    // change an address that is already being offered.
    logic [31:0] issue_addr;
    // Set when the in-flight response belongs to a fetch cancelled by a redirect.
    logic        drop;

    assign arvalid = (state == IFU_ISSUE);
    assign rready  = (state == IFU_WAIT_R);
    assign araddr  = issue_addr;

    // Fetch FSM, pc, output register and fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IFU_ISSUE;
            pc               <= RESET_PC;
            issue_addr       <= RESET_PC;
            drop             <= 1'b0;
            ifu_valid        <= 1'b0;
            fu_to_du_bus     <= '0;
            ifu_access_fault <= 1'b0;
        end else begin
            unique case (state)
                IFU_ISSUE: begin
                    // AR cannot be withdrawn: let it complete and discard its data.
                    if (exu_dnpc_valid) begin
                        pc   <= exu_dnpc;
                        drop <= 1'b1;
                    end
                    if (arready) begin
                        state <= IFU_WAIT_R;
                    end
                end
                IFU_WAIT_R: begin
                    if (rvalid) begin
                        if (exu_dnpc_valid) begin
                            pc         <= exu_dnpc;
                            issue_addr <= exu_dnpc;
                            drop       <= 1'b0;
                            state      <= IFU_ISSUE;
                        end else if (drop) begin
                            issue_addr <= pc;
                            drop       <= 1'b0;
                            state      <= IFU_ISSUE;
                        end else begin
                            fu_to_du_bus <= {pc, rdata};
                            ifu_valid    <= 1'b1;
                            state        <= IFU_HOLD;
                            if (rresp != RESP_OKAY) begin
                                ifu_access_fault <= 1'b1;
                            end
                        end
                    end else if (exu_dnpc_valid) begin
                        pc   <= exu_dnpc;
                        drop <= 1'b1;
                    end
                end
                IFU_HOLD: begin
                    if (exu_dnpc_valid) begin
                        pc         <= exu_dnpc;
                        issue_addr <= exu_dnpc;
                        ifu_valid  <= 1'b0;
                        state      <= IFU_ISSUE;
                    end else if (idu_ready) begin
                        pc         <= next_seq_pc(pc);
                        issue_addr <= next_seq_pc(pc);
                        ifu_valid  <= 1'b0;
                        state      <= IFU_ISSUE;
                    end
                end
                default: begin
                    state <= IFU_ISSUE;
                end
            endcase
        end
    end

`ifdef YSYX_25020037_IFU_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    // Count accepted instructions (a same-cycle redirect cancels the handoff) and stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (ifu_valid && idu_ready && !exu_dnpc_valid) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (ifu_valid && !idu_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Directed scoreboard bench for ysyx_25020037_ifu with a small AXI4-Lite read memory.
module tb_ysyx_25020037_ifu;
    import ysyx_25020037_ifu_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       idu_ready;
    logic                       ifu_valid;
    logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus;
    logic                       exu_dnpc_valid;
    logic [31:0]                exu_dnpc;
    logic [31:0]                araddr;
    logic                       arvalid;
    logic                       arready;
    logic [31:0]                rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;
    logic                       ifu_access_fault;
    logic [31:0]                perf_fetch_cnt;
    logic [31:0]                perf_stall_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] ar_q[$];
    logic [63:0] exp_q[$];

    // Memory model controls.
    logic        arready_en;
    int unsigned r_delay;
    logic [1:0]  resp_cfg;
    logic        mem_busy;
    logic [31:0] mem_addr;
    int unsigned lat;

    always #5 clk = ~clk;

    ysyx_25020037_ifu dut (
        .clk              (clk),
        .rst              (rst),
        .idu_ready        (idu_ready),
        .ifu_valid        (ifu_valid),
        .fu_to_du_bus     (fu_to_du_bus),
        .exu_dnpc_valid   (exu_dnpc_valid),
        .exu_dnpc         (exu_dnpc),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .arready          (arready),
        .rdata            (rdata),
        .rresp            (rresp),
        .rvalid           (rvalid),
        .rready           (rready),
        .ifu_access_fault (ifu_access_fault),
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] ent(input logic [31:0] a);
        return {a, mdata(a)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60 && !ifu_valid; i++) tick();
        check("wait_valid", 64'(ifu_valid), 64'd1);
    endtask

    task automatic wait_rready();
        for (int i = 0; i < 60 && !rready; i++) tick();
        check("wait_rready", 64'(rready), 64'd1);
    endtask

    // Memory: arready when idle, rvalid r_delay cycles (plus one) after AR acceptance.
    assign arready = arready_en && !mem_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_busy <= 1'b0;
            mem_addr <= '0;
            lat      <= 0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= '0;
        end else begin
            if (arvalid && arready) begin
                mem_busy <= 1'b1;
                mem_addr <= araddr;
                if (r_delay == 0) begin
                    rvalid <= 1'b1;
                    rdata  <= mdata(araddr);
                    rresp  <= resp_cfg;
                end else begin
                    lat <= r_delay;
                end
            end else if (mem_busy && !rvalid && lat != 0) begin
                lat <= lat - 1;
                if (lat == 1) begin
                    rvalid <= 1'b1;
                    rdata  <= mdata(mem_addr);
                    rresp  <= resp_cfg;
                end
            end
            if (rvalid && rready) begin
                rvalid   <= 1'b0;
                mem_busy <= 1'b0;
            end
        end
    end

    // Scoreboard monitor, evaluated mid-cycle on the handshakes about to complete.
    always @(negedge clk) begin
        if (!rst) begin
            if (arvalid && arready) begin
                if (ar_q.size() == 0) check("ar_unexpected", 64'(araddr), 64'hFFFF_FFFF);
                else check("araddr", 64'(araddr), 64'(ar_q.pop_front()));
            end
            if (ifu_valid && idu_ready && !exu_dnpc_valid) begin
                if (exp_q.size() == 0) check("deliver_unexpected", fu_to_du_bus, 64'hFFFF_FFFF);
                else check("deliver", fu_to_du_bus, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] exp_stall;
        logic [31:0] exp_fetch;

        rst            = 1'b1;
        idu_ready      = 1'b1;
        exu_dnpc_valid = 1'b0;
        exu_dnpc       = '0;
        arready_en     = 1'b1;
        r_delay        = 0;
        resp_cfg       = 2'b00;
        tick(2);

        // Reset values.
        check("rst_arvalid", 64'(arvalid), 64'd1);
        check("rst_araddr", 64'(araddr), 64'h3000_0000);
        check("rst_ifu_valid", 64'(ifu_valid), 64'd0);
        check("rst_bus", fu_to_du_bus, 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_fault", 64'(ifu_access_fault), 64'd0);
        check("rst_fetch_cnt", 64'(perf_fetch_cnt), 64'd0);
        check("rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);

        // Streaming fetch with zero-latency memory.
        for (int i = 0; i < 4; i++) begin
            ar_q.push_back(32'h3000_0000 + 32'(4 * i));
            exp_q.push_back(ent(32'h3000_0000 + 32'(4 * i)));
        end
        rst = 1'b0;
        #1;
        check("lat_ar_hs", 64'(arvalid && arready), 64'd1);
        tick();
        check("lat_rvalid", 64'(rvalid && rready), 64'd1);
        check("lat_valid_n1", 64'(ifu_valid), 64'd0);
        tick();
        check("lat_valid_n2", 64'(ifu_valid), 64'd1);
        for (int i = 0; i < 40 && exp_q.size() > 1; i++) tick();
        check("stream_left", 64'(exp_q.size()), 64'd1);
        idu_ready = 1'b0;

        // Stall in HOLD for five cycles.
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(ifu_valid), 64'd1);
            check("stall_bus", fu_to_du_bus, ent(32'h3000_000C));
            if (i < 4) tick();
        end
        tick();
`ifdef YSYX_25020037_IFU_PERF_EN
        exp_stall = 32'd5;
        exp_fetch = 32'd3;
`else
        exp_stall = 32'd0;
        exp_fetch = 32'd0;
`endif
        check("stall_cnt", 64'(perf_stall_cnt), 64'(exp_stall));
        check("fetch_cnt", 64'(perf_fetch_cnt), 64'(exp_fetch));

        // Redirect while waiting for a slow response.
        r_delay = 3;
        ar_q.push_back(32'h3000_0010);
        ar_q.push_back(32'h3000_0100);
        exp_q.push_back(ent(32'h3000_0100));
        idu_ready = 1'b1;
        tick();
        wait_rready();
        idu_ready      = 1'b0;
        exu_dnpc_valid = 1'b1;
        exu_dnpc       = 32'h3000_0100;
        tick();
        exu_dnpc_valid = 1'b0;
        r_delay        = 0;
        wait_valid();
        check("redir_wait_bus", fu_to_du_bus, ent(32'h3000_0100));

        // Redirect in the same cycle as the decode handshake.
        void'(exp_q.pop_front());
        ar_q.push_back(32'h3000_0200);
        exp_q.push_back(ent(32'h3000_0200));
        idu_ready      = 1'b1;
        exu_dnpc_valid = 1'b1;
        exu_dnpc       = 32'h3000_0200;
        tick();
        idu_ready      = 1'b0;
        exu_dnpc_valid = 1'b0;
        check("redir_hold_valid", 64'(ifu_valid), 64'd0);
        wait_valid();
        check("redir_hold_bus", fu_to_du_bus, ent(32'h3000_0200));

        // Redirect while AR is back-pressured.
        arready_en = 1'b0;
        ar_q.push_back(32'h3000_0204);
        ar_q.push_back(32'h3000_0300);
        exp_q.push_back(ent(32'h3000_0300));
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        check("bp_arvalid0", 64'(arvalid), 64'd1);
        check("bp_araddr0", 64'(araddr), 64'h3000_0204);
        exu_dnpc_valid = 1'b1;
        exu_dnpc       = 32'h3000_0300;
        tick();
        exu_dnpc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_arvalid", 64'(arvalid), 64'd1);
            check("bp_araddr", 64'(araddr), 64'h3000_0204);
            tick();
        end
        arready_en = 1'b1;
        wait_valid();
        check("bp_bus", fu_to_du_bus, ent(32'h3000_0300));

        // Error response: delivered, fault flag sticky.
        resp_cfg = 2'b10;
        ar_q.push_back(32'h3000_0304);
        exp_q.push_back(ent(32'h3000_0304));
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        check("fault_before", 64'(ifu_access_fault), 64'd0);
        wait_valid();
        check("fault_bus", fu_to_du_bus, ent(32'h3000_0304));
        check("fault_set", 64'(ifu_access_fault), 64'd1);
        resp_cfg = 2'b00;
        ar_q.push_back(32'h3000_0308);
        exp_q.push_back(ent(32'h3000_0308));
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        wait_valid();
        check("fault_sticky", 64'(ifu_access_fault), 64'd1);

        // Reset in the middle of a read.
        r_delay = 3;
        ar_q.push_back(32'h3000_030C);
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        wait_rready();
        rst = 1'b1;
        #1;
        check("mid_rst_fault", 64'(ifu_access_fault), 64'd0);
        check("mid_rst_valid", 64'(ifu_valid), 64'd0);
        check("mid_rst_bus", fu_to_du_bus, 64'd0);
        check("mid_rst_araddr", 64'(araddr), 64'h3000_0000);
        check("mid_rst_rready", 64'(rready), 64'd0);
        tick(2);
        r_delay = 0;
        ar_q.delete();
        exp_q.delete();
        ar_q.push_back(32'h3000_0000);
        exp_q.push_back(ent(32'h3000_0000));
        rst = 1'b0;
        wait_valid();
        check("post_rst_bus", fu_to_du_bus, ent(32'h3000_0000));
        check("post_rst_fetch_cnt", 64'(perf_fetch_cnt), 64'd0);
        check("post_rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);
        check("end_ar_q", 64'(ar_q.size()), 64'd0);
        check("end_exp_q", 64'(exp_q.size()), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
